irq_sched_ctrl: RTL and testbench

//  Sequenced CPU interrupt controller.
//  - Captures rising edges on N_IRQ request lines into a pending register.
//  - Applies a per-line mask and picks the highest-priority eligible line (index 0 highest).
//  - Presents the winning line's ID to the CPU over an irq/ack handshake.
//  - Holds it in-service until the CPU signals end-of-interrupt.
//  - Sits between peripheral interrupt sources and the CPU core.

---
 rtl/irq_sched_pkg.sv | 12 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_sched_ctrl.sv | 98 +++++++++
 tb/tb_irq_sched_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_sched_pkg.sv
// Shared types and defaults for the sequenced interrupt controller.
package irq_sched_pkg;

  localparam int N_IRQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module irq_prio_enc #(
  parameter  int N_IRQ = 4,
  localparam int ID_W  = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Walk from the top index down so the lowest set index is written last.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_sched_ctrl.sv
// Interrupt controller: edge capture into pending, masked priority pick,
// irq/ack presentation and in-service hold until end-of-interrupt.
//   state   | meaning
//   IDLE    | nothing presented; waits for an eligible pending line
//   REQ     | irq_o high with a frozen id; waits for ack or withdraws on mask
//   SERVICE | CPU is servicing id_q; waits for eoi
module irq_sched_ctrl
  import irq_sched_pkg::*;
#(
  parameter  int N_IRQ = N_IRQ_DEF,
  localparam int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             ack_i,
  input  logic             eoi_i,
  output logic             in_service_o,
  output logic [N_IRQ-1:0] pending_o
);

  irq_state_e       state;
  logic [N_IRQ-1:0] irq_in_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  win_id;
  logic             win_v;

  assign elig      = pending & ~irq_mask_i;
  assign set_vec   = irq_in & ~irq_in_q;
  assign clr_vec   = (state == REQ && ack_i) ? (N_IRQ'(1) << id_q) : '0;
  assign pending_o = pending;
  assign irq_id_o  = id_q;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_enc (
    .req   (elig),
    .valid (win_v),
    .id    (win_id)
  );

  // Set is OR-ed in after the clear so a fresh edge on the acked line survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_in_q <= '0;
      pending  <= '0;
    end else begin
      irq_in_q <= irq_in;
      pending  <= (pending & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      id_q         <= '0;
      irq_o        <= 1'b0;
      in_service_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_v) begin
            id_q  <= win_id;
            irq_o <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (ack_i) begin
            irq_o        <= 1'b0;
            in_service_o <= 1'b1;
            state        <= SERVICE;
          end else if (!elig[id_q]) begin
            irq_o <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi_i) begin
            in_service_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          irq_o        <= 1'b0;
          in_service_o <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_sched_ctrl.sv
// Bench for irq_sched_ctrl: directed scenarios then random traffic, all
// checked every cycle against a transaction-level model of the controller.
module tb_irq_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] irq_mask_i;
  logic       irq_o;
  logic [1:0] irq_id_o;
  logic       ack_i;
  logic       eoi_i;
  logic       in_service_o;
  logic [3:0] pending_o;

  int total = 0;
  int bad   = 0;

  // Model: 0 = nothing offered, 1 = offered to CPU, 2 = CPU servicing
  int       m_phase;
  int       m_id;
  bit [3:0] m_pend;
  bit [3:0] m_prev;
  int       services;

  irq_sched_ctrl #(.N_IRQ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .irq_mask_i   (irq_mask_i),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o),
    .ack_i        (ack_i),
    .eoi_i        (eoi_i),
    .in_service_o (in_service_o),
    .pending_o    (pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_id    = 0;
    m_pend  = '0;
    m_prev  = '0;
  endtask

  task automatic check_outputs();
    chk("irq_o", 32'(irq_o), 32'(m_phase == 1));
    chk("in_service", 32'(in_service_o), 32'(m_phase == 2));
    chk("irq_id", 32'(irq_id_o), 32'(m_id));
    chk("pending", 32'(pending_o), 32'(m_pend));
  endtask

  // One clock: the model consumes the inputs presented at this edge.
  task automatic step();
    bit [3:0] rise;
    bit [3:0] elig;
    bit [3:0] clr;
    @(posedge clk);
    rise = irq_in & ~m_prev;
    elig = m_pend & ~irq_mask_i;
    clr  = '0;
    if (m_phase == 0) begin
      if (elig != 0) begin
        m_id    = lowest(elig);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ack_i) begin
        clr[m_id] = 1'b1;
        m_phase   = 2;
        services++;
      end else if (!elig[m_id]) begin
        m_phase = 0;
      end
    end else if (eoi_i) begin
      m_phase = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq_in;
    #1;
    check_outputs();
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    step();
    irq_in = '0;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
  endtask

  task automatic do_eoi();
    eoi_i = 1'b1;
    step();
    eoi_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; irq_mask_i = '0; ack_i = 1'b0; eoi_i = 1'b0;
    services = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // single edge on line 2, visible two cycles after the sampling edge
    pulse(4'b0100);
    step();
    chk("single_req", 32'(irq_o), 32'd1);
    chk("single_id", 32'(irq_id_o), 32'd2);
    do_ack();
    chk("single_pend_clr", 32'(pending_o), 32'd0);
    do_eoi();
    chk("single_eoi", 32'(in_service_o), 32'd0);

    // simultaneous edges: line 1 before line 3
    pulse(4'b1010);
    step();
    chk("prio_first", 32'(irq_id_o), 32'd1);
    do_ack();
    chk("prio_pend", 32'(pending_o), 32'h8);
    do_eoi();
    step();
    chk("prio_second", 32'(irq_id_o), 32'd3);

    // higher-priority arrival while presenting id 3
    irq_in = 4'b0001;
    repeat (3) step();
    chk("stable_id", 32'(irq_id_o), 32'd3);
    irq_in = '0;
    do_ack();
    do_eoi();
    step();
    chk("late_id0", 32'(irq_id_o), 32'd0);
    do_ack();
    do_eoi();

    // mask withdraw and re-present
    pulse(4'b0100);
    step();
    irq_mask_i = 4'b0100;
    step();
    chk("withdraw_irq", 32'(irq_o), 32'd0);
    chk("withdraw_pend", 32'(pending_o[2]), 32'd1);
    step();
    irq_mask_i = '0;
    step();
    chk("represent_id", 32'(irq_id_o), 32'd2);
    do_ack();
    do_eoi();

    // level held high: only one service, stray handshakes ignored
    services = 0;
    irq_in = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      ack_i = (m_phase == 1);
      eoi_i = (m_phase == 2);
      step();
    end
    ack_i = 1'b1; eoi_i = 1'b1;
    step();
    ack_i = 1'b0; eoi_i = 1'b0;
    irq_in = '0;
    step();
    chk("level_once", 32'(services), 32'd1);

    // reset mid-service
    pulse(4'b1001);
    step();
    do_ack();
    chk("pre_rst_svc", 32'(in_service_o), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'($urandom);
      if ($urandom_range(0, 15) == 0) irq_mask_i = 4'($urandom) & 4'($urandom);
      ack_i = (m_phase == 1 && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0;
      eoi_i = (m_phase == 2 && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
